// File: rtl/reset_sequencer.sv
// Staged reset release (sdram -> sys -> cpu) gated by a stable PLL lock and a debounced reset button.
// Optional macro PLL_LOCK_MONITOR_EN adds a saturating lock-loss event counter on lock_loss_count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all resets held; counting consecutive stable-lock cycles
// REL_SDRAM | sdram_reset released; timing the stage delay
// REL_SYS   | sdram/sys resets released; timing the stage delay
// RUN       | all resets released, ready high until lock loss or button

module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_DELAY         = 16,
  parameter int BTN_DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       btn_reset_n,
  output logic       sdram_reset,
  output logic       sys_reset,
  output logic       cpu_reset,
  output logic       ready
`ifdef PLL_LOCK_MONITOR_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(BTN_DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_LOCK, REL_SDRAM, REL_SYS, RUN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_db_cnt;
  logic            r_btn_act;
  logic            r_lock_meta, r_locked_s;
  logic            r_btn_meta, r_btn_s;
  logic            r_sdram_reset, r_sys_reset, r_cpu_reset, r_ready;
  logic            w_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
      r_btn_meta  <= 1'b0;
      r_btn_s     <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_locked_s  <= r_lock_meta;
      r_btn_meta  <= btn_reset_n;
      r_btn_s     <= r_btn_meta;
    end
  end

  // btn_act latches once the press has lasted long enough and drops on the first released sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt  <= '0;
      r_btn_act <= 1'b0;
    end else if (r_btn_s) begin
      r_db_cnt  <= '0;
      r_btn_act <= 1'b0;
    end else if (r_db_cnt == DW'(BTN_DEBOUNCE_CYCLES - 1)) begin
      r_btn_act <= 1'b1;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_abort = (r_state != WAIT_LOCK) && (!r_locked_s || r_btn_act);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= WAIT_LOCK;
      r_cnt         <= '0;
      r_sdram_reset <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_cpu_reset   <= 1'b1;
      r_ready       <= 1'b0;
    end else if (w_abort) begin
      r_state       <= WAIT_LOCK;
      r_cnt         <= '0;
      r_sdram_reset <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_cpu_reset   <= 1'b1;
      r_ready       <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (!r_locked_s || r_btn_act) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            r_state       <= REL_SDRAM;
            r_cnt         <= '0;
            r_sdram_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REL_SDRAM: begin
          if (r_cnt == CW'(STAGE_DELAY - 1)) begin
            r_state     <= REL_SYS;
            r_cnt       <= '0;
            r_sys_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REL_SYS: begin
          if (r_cnt == CW'(STAGE_DELAY - 1)) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_cpu_reset <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          r_cnt <= '0;
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sdram_reset = r_sdram_reset;
  assign sys_reset   = r_sys_reset;
  assign cpu_reset   = r_cpu_reset;
  assign ready       = r_ready;

`ifdef PLL_LOCK_MONITOR_EN
  logic       r_locked_d;
  logic [7:0] r_lock_loss_cnt;

  // A lock drop seen outside WAIT_LOCK is one event, counted on the same edge the FSM aborts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked_d      <= 1'b0;
      r_lock_loss_cnt <= 8'd0;
    end else begin
      r_locked_d <= r_locked_s;
      if (r_locked_d && !r_locked_s && (r_state != WAIT_LOCK) && (r_lock_loss_cnt != 8'hFF))
        r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_count = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_STABLE_CYCLES=8, STAGE_DELAY=4, BTN_DEBOUNCE_CYCLES=4.
// Edge numbers below count rising edges after the reference edge at which a stimulus change is made.

module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic pll_locked;
  logic btn_reset_n;
  logic sdram_reset, sys_reset, cpu_reset, ready;
`ifdef PLL_LOCK_MONITOR_EN
  logic [7:0] lock_loss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .STAGE_DELAY        (4),
    .BTN_DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .btn_reset_n    (btn_reset_n),
    .sdram_reset    (sdram_reset),
    .sys_reset      (sys_reset),
    .cpu_reset      (cpu_reset),
    .ready          (ready)
`ifdef PLL_LOCK_MONITOR_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_held(input string tag);
    chk({tag, ".sdram"}, 32'(sdram_reset), 32'd1);
    chk({tag, ".sys"},   32'(sys_reset),   32'd1);
    chk({tag, ".cpu"},   32'(cpu_reset),   32'd1);
    chk({tag, ".ready"}, 32'(ready),       32'd0);
  endtask

  // Called just after the reference edge; sdram falls at edge lead, sys at lead+4, cpu/ready at lead+8
  task automatic chk_seq(input string tag, input int lead);
    step(lead - 1);
    chk({tag, ".sdram_pre"}, 32'(sdram_reset), 32'd1);
    step(1);
    chk({tag, ".sdram_rel"}, 32'(sdram_reset), 32'd0);
    chk({tag, ".sys_hold"},  32'(sys_reset),   32'd1);
    step(3);
    chk({tag, ".sys_pre"},   32'(sys_reset),   32'd1);
    step(1);
    chk({tag, ".sys_rel"},   32'(sys_reset),   32'd0);
    chk({tag, ".cpu_hold"},  32'(cpu_reset),   32'd1);
    step(3);
    chk({tag, ".cpu_pre"},   32'(cpu_reset),   32'd1);
    chk({tag, ".rdy_pre"},   32'(ready),       32'd0);
    step(1);
    chk({tag, ".cpu_rel"},   32'(cpu_reset),   32'd0);
    chk({tag, ".rdy_rel"},   32'(ready),       32'd1);
    chk({tag, ".sdram_run"}, 32'(sdram_reset), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    pll_locked  = 1'b0;
    btn_reset_n = 1'b1;
    step(3);
    chk_all_held("reset");
`ifdef PLL_LOCK_MONITOR_EN
    chk("reset.llc", 32'(lock_loss_count), 32'd0);
`endif

    // Basic release: lock present from the first cycle out of reset
    reset      = 1'b0;
    pll_locked = 1'b1;
    chk_seq("basic", 10);

    // Lock glitch after 6 stable cycles in WAIT_LOCK restarts the stability count
    reset = 1'b1;
    pll_locked = 1'b0;
    step(2);
    reset      = 1'b0;
    pll_locked = 1'b1;
    step(6);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(3);
    chk("glitch.no_early", 32'(sdram_reset), 32'd1);
    chk_seq("glitch", 7);

    // Lock loss in RUN: synchronizer plus one registered stage
    pll_locked = 1'b0;
    step(2);
    chk("lossrun.still_ready", 32'(ready), 32'd1);
    step(1);
    chk_all_held("lossrun");
    step(4);
    chk_all_held("lossrun.wait");
    pll_locked = 1'b1;
    chk_seq("relock", 10);
`ifdef PLL_LOCK_MONITOR_EN
    chk("relock.llc", 32'(lock_loss_count), 32'd1);
`endif

    // Button held 3 cycles: too short to trigger
    btn_reset_n = 1'b0;
    step(3);
    btn_reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("btnshort.ready", 32'(ready), 32'd1);
    end

    // Button held 10 cycles: resets assert at edge 7 and stay while held
    btn_reset_n = 1'b0;
    step(6);
    chk("btnlong.pre_ready", 32'(ready), 32'd1);
    step(1);
    chk_all_held("btnlong");
    step(3);
    chk_all_held("btnlong.held");
    btn_reset_n = 1'b1;
    chk_seq("btnrel", 11);

    // Synchronous reset while in REL_SYS
    pll_locked = 1'b0;
    step(8);
    pll_locked = 1'b1;
    step(15);
    chk("rstsys.sys_low", 32'(sys_reset), 32'd0);
    chk("rstsys.cpu_high", 32'(cpu_reset), 32'd1);
    reset = 1'b1;
    step(1);
    chk_all_held("rstsys");
    reset = 1'b0;
    chk_seq("after_rst", 10);

`ifdef PLL_LOCK_MONITOR_EN
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      step(5);
      pll_locked = 1'b1;
      step(20);
    end
    chk("sat.ready", 32'(ready), 32'd1);
    chk("sat.llc", 32'(lock_loss_count), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before the first reset release (min 1).
REQ-002 SHALL have parameter STAGE_DELAY, default 16: cycles between successive reset releases (min 1).
REQ-003 SHALL have parameter BTN_DEBOUNCE_CYCLES, default 65536: consecutive cycles of a pressed button required to trigger a reset (min 1).
REQ-004 SHALL have port clk, input, 1: the single clock, the 50 MHz system clock from the main PLL secondary output.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port pll_locked, input, 1: PLL lock indication, asynchronous to clk.
REQ-007 SHALL have port btn_reset_n, input, 1: user reset button, active-low, asynchronous.
REQ-008 SHALL have port sdram_reset, output, 1: memory-controller reset, active-high.
REQ-009 SHALL have port sys_reset, output, 1: bus/peripheral reset, active-high.
REQ-010 SHALL have port cpu_reset, output, 1: CPU reset, active-high.
REQ-011 SHALL have port ready, output, 1: high only in RUN.
REQ-012 SHALL have port lock_loss_count, output, 8: saturating lock-loss event count, present only with PLL_LOCK_MONITOR_EN.

Function
REQ-013 SHALL pass pll_locked and btn_reset_n through two-flop synchronizers, giving locked_s and btn_s.
REQ-014 SHALL assert btn_act after btn_s has been 0 for BTN_DEBOUNCE_CYCLES consecutive cycles, and SHALL clear btn_act and the debounce counter in the first cycle btn_s is 1.
REQ-015 SHALL implement states WAIT_LOCK, REL_SDRAM, REL_SYS, RUN with one shared counter wide enough for max(LOCK_STABLE_CYCLES, STAGE_DELAY).
REQ-016 In WAIT_LOCK: all three resets high; counter increments while locked_s=1 and btn_act=0, clears otherwise; at LOCK_STABLE_CYCLES-1 the FSM SHALL move to REL_SDRAM with the counter cleared.
REQ-017 In REL_SDRAM: sdram_reset low, others high; after STAGE_DELAY cycles the FSM SHALL move to REL_SYS.
REQ-018 In REL_SYS: sdram_reset and sys_reset low, cpu_reset high; after STAGE_DELAY cycles the FSM SHALL move to RUN.
REQ-019 In RUN: all resets low, ready high; the FSM SHALL stay in RUN until an abort.
REQ-020 Abort: in any state other than WAIT_LOCK, locked_s=0 or btn_act=1 SHALL move the FSM to WAIT_LOCK, clear the counter, and assert all resets and deassert ready on the next clock edge.
REQ-021 Priority SHALL be reset > lock loss > button > normal progression.
REQ-022 Outputs SHALL be registered; resets release strictly in order sdram, sys, cpu, and re-assert simultaneously.
REQ-023 Latency from a pll_locked rise that meets setup to the sdram_reset fall SHALL be 2+LOCK_STABLE_CYCLES cycles.

Reset
REQ-024 On reset=1 the block SHALL enter WAIT_LOCK, with counters zero, sdram_reset=sys_reset=cpu_reset=1, ready=0, btn_act=0, synchronizer flops 0, and lock_loss_count=0.
REQ-025 reset asserted mid-sequence SHALL take effect at the next edge, regardless of state.

Configuration
REQ-026 With macro PLL_LOCK_MONITOR_EN defined: lock_loss_count SHALL increment by 1 on each cycle where locked_s falls 1->0 while the state is not WAIT_LOCK, and SHALL saturate at 255.
REQ-027 Without PLL_LOCK_MONITOR_EN: the lock_loss_count port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (LOCK_STABLE_CYCLES=8, STAGE_DELAY=4, BTN_DEBOUNCE_CYCLES=4)
REQ-028 Release reset at cycle 0 with pll_locked=1 from cycle 0 -> sdram_reset falls at cycle 10, sys_reset at 14, cpu_reset and ready at 18.
REQ-029 In WAIT_LOCK, drop pll_locked for 1 cycle after 6 stable cycles -> counter restarts and sdram_reset falls 10 cycles after pll_locked returns.
REQ-030 In RUN, drop pll_locked -> all resets high and ready 0 within 3 cycles; on relock the full sequence repeats 10/14/18; lock_loss_count=1 with the macro.
REQ-031 In RUN, hold btn_reset_n low for 3 cycles -> no change; hold it for 4+ cycles -> all resets assert; they stay asserted while the button is held, and the sequence restarts after release.
REQ-032 Assert reset in REL_SYS -> next edge gives all resets high, ready 0, state WAIT_LOCK.
REQ-033 With the macro, perform 300 lock-loss events from RUN -> lock_loss_count reads 255.
